// File: rtl/stream_mux.sv
// Two-source packet stream multiplexer: round-robin arbitration between A and B,
// packet locking until LAST, and a single registered output stage tagged with its source.
module stream_mux #(
  parameter int WIDTH = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [WIDTH-1:0] A_DATA,
  input  logic             A_LAST,
  input  logic             A_VALID,
  output logic             A_READY,
  input  logic [WIDTH-1:0] B_DATA,
  input  logic             B_LAST,
  input  logic             B_VALID,
  output logic             B_READY,
  output logic [WIDTH-1:0] OUT_DATA,
  output logic             OUT_LAST,
  output logic             OUT_SEL,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [1:0]       dbg_state,
  output logic             dbg_prio
);

  // Handshake: a beat moves on any port when VALID and READY are both high at a
  // rising CLK edge; a source holds DATA/LAST stable while VALID is high and READY low.

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOCK_A = 2'd1,
    LOCK_B = 2'd2
  } state_t;

  state_t state, state_next;
  logic   prio, prio_next;
  logic   load;
  logic   grant_a, grant_b;
  logic   take_a, take_b;

  // The output register can accept a beat when it is empty or drains this cycle.
  assign load = !OUT_VALID || OUT_READY;

  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    case (state)
      IDLE: begin
        if (A_VALID && (!B_VALID || !prio)) begin
          grant_a = 1'b1;
        end else if (B_VALID) begin
          grant_b = 1'b1;
        end
      end
      LOCK_A:  grant_a = 1'b1;
      LOCK_B:  grant_b = 1'b1;
      default: begin
        grant_a = 1'b0;
        grant_b = 1'b0;
      end
    endcase
  end

  assign A_READY = load && grant_a && !RESET;
  assign B_READY = load && grant_b && !RESET;
  assign take_a  = A_VALID && A_READY;
  assign take_b  = B_VALID && B_READY;

  // Lock on a non-LAST beat; on LAST return to IDLE and favour the other source.
  always_comb begin
    state_next = state;
    prio_next  = prio;
    if (take_a) begin
      if (A_LAST) begin
        state_next = IDLE;
        prio_next  = 1'b1;
      end else begin
        state_next = LOCK_A;
      end
    end else if (take_b) begin
      if (B_LAST) begin
        state_next = IDLE;
        prio_next  = 1'b0;
      end else begin
        state_next = LOCK_B;
      end
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state <= IDLE;
      prio  <= 1'b0;
    end else begin
      state <= state_next;
      prio  <= prio_next;
    end
  end

  // Payload fields only change on a load, so they hold after the beat drains.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      OUT_DATA  <= '0;
      OUT_LAST  <= 1'b0;
      OUT_SEL   <= 1'b0;
      OUT_VALID <= 1'b0;
    end else if (take_a) begin
      OUT_DATA  <= A_DATA;
      OUT_LAST  <= A_LAST;
      OUT_SEL   <= 1'b0;
      OUT_VALID <= 1'b1;
    end else if (take_b) begin
      OUT_DATA  <= B_DATA;
      OUT_LAST  <= B_LAST;
      OUT_SEL   <= 1'b1;
      OUT_VALID <= 1'b1;
    end else if (OUT_READY) begin
      OUT_VALID <= 1'b0;
    end
  end

  assign dbg_state = state;
  assign dbg_prio  = prio;

endmodule

// File: tb/tb_stream_mux.sv
// Bench for stream_mux: a per-cycle vector table with expected READYs, a scoreboard
// queue of expected output beats, and a short random single-source run.
module tb_stream_mux;

  localparam int WIDTH = 16;
  localparam int EW    = WIDTH + 2;

  logic             CLK = 1'b0;
  logic             RESET = 1'b1;
  logic [WIDTH-1:0] A_DATA = '0;
  logic             A_LAST = 1'b0;
  logic             A_VALID = 1'b0;
  logic             A_READY;
  logic [WIDTH-1:0] B_DATA = '0;
  logic             B_LAST = 1'b0;
  logic             B_VALID = 1'b0;
  logic             B_READY;
  logic [WIDTH-1:0] OUT_DATA;
  logic             OUT_LAST;
  logic             OUT_SEL;
  logic             OUT_VALID;
  logic             OUT_READY = 1'b0;
  logic [1:0]       dbg_state;
  logic             dbg_prio;

  stream_mux #(.WIDTH(WIDTH)) dut (
    .CLK(CLK), .RESET(RESET),
    .A_DATA(A_DATA), .A_LAST(A_LAST), .A_VALID(A_VALID), .A_READY(A_READY),
    .B_DATA(B_DATA), .B_LAST(B_LAST), .B_VALID(B_VALID), .B_READY(B_READY),
    .OUT_DATA(OUT_DATA), .OUT_LAST(OUT_LAST), .OUT_SEL(OUT_SEL),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .dbg_state(dbg_state), .dbg_prio(dbg_prio)
  );

  // clock / reset
  always #5 CLK = ~CLK;

  typedef struct packed {
    logic             rst;
    logic             av;
    logic [WIDTH-1:0] ad;
    logic             al;
    logic             bv;
    logic [WIDTH-1:0] bd;
    logic             bl;
    logic             ordy;
    logic             ear;
    logic             ebr;
  } vec_t;

  vec_t           tbl[$];
  logic [EW-1:0]  exp_q[$];
  int             checks = 0;
  int             errors = 0;

  function automatic vec_t mk(input logic rst, input logic av, input logic [WIDTH-1:0] ad,
                              input logic al, input logic bv, input logic [WIDTH-1:0] bd,
                              input logic bl, input logic ordy, input logic ear,
                              input logic ebr);
    vec_t v;
    v.rst = rst; v.av = av; v.ad = ad; v.al = al;
    v.bv = bv; v.bd = bd; v.bl = bl; v.ordy = ordy;
    v.ear = ear; v.ebr = ebr;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got 0x%0h expected 0x%0h", name, idx, act, exp);
    end
  endtask

  // driver + scoreboard: one call per clock cycle
  task automatic step(input vec_t v, input int idx);
    logic [EW-1:0] e;
    @(negedge CLK);
    RESET     = v.rst;
    A_VALID   = v.av;  A_DATA = v.ad; A_LAST = v.al;
    B_VALID   = v.bv;  B_DATA = v.bd; B_LAST = v.bl;
    OUT_READY = v.ordy;
    #1;
    chk("a_ready", idx, 32'(A_READY), 32'(v.ear));
    chk("b_ready", idx, 32'(B_READY), 32'(v.ebr));
    if (v.rst) begin
      exp_q.delete();
      chk("rst_out_valid", idx, 32'(OUT_VALID), 32'd0);
      chk("rst_out_data", idx, 32'(OUT_DATA), 32'd0);
      chk("rst_out_last", idx, 32'(OUT_LAST), 32'd0);
      chk("rst_out_sel", idx, 32'(OUT_SEL), 32'd0);
      chk("rst_state", idx, 32'(dbg_state), 32'd0);
      chk("rst_prio", idx, 32'(dbg_prio), 32'd0);
    end else begin
      if (exp_q.size() != 0) begin
        e = exp_q[0];
        chk("out_valid", idx, 32'(OUT_VALID), 32'd1);
        chk("out_data", idx, 32'(OUT_DATA), 32'(e[EW-1:2]));
        chk("out_last", idx, 32'(OUT_LAST), 32'(e[1]));
        chk("out_sel", idx, 32'(OUT_SEL), 32'(e[0]));
        if (v.ordy) void'(exp_q.pop_front());
      end else begin
        chk("out_valid", idx, 32'(OUT_VALID), 32'd0);
      end
      if (v.av && v.ear) exp_q.push_back({v.ad, v.al, 1'b0});
      if (v.bv && v.ebr) exp_q.push_back({v.bd, v.bl, 1'b1});
    end
  endtask

  initial begin
    vec_t v;
    logic exp_full;
    logic ordy;
    logic last;
    logic [WIDTH-1:0] d;

    //               rst av  ad        al  bv  bd        bl  ordy ear ebr
    // single A beat, then PRIO=B wins a tie
    tbl.push_back(mk(0, 1, 16'h1234, 1, 0, 16'h0000, 0, 1, 1, 0));
    tbl.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h0000, 0, 1, 0, 0));
    tbl.push_back(mk(0, 1, 16'h00AA, 1, 1, 16'h00BB, 1, 1, 0, 1));
    tbl.push_back(mk(1, 0, 16'h0000, 0, 0, 16'h0000, 0, 1, 0, 0));
    // alternating single-beat packets
    tbl.push_back(mk(0, 1, 16'h000A, 1, 1, 16'h000B, 1, 1, 1, 0));
    tbl.push_back(mk(0, 1, 16'h000A, 1, 1, 16'h000B, 1, 1, 0, 1));
    tbl.push_back(mk(0, 1, 16'h000A, 1, 1, 16'h000B, 1, 1, 1, 0));
    tbl.push_back(mk(0, 1, 16'h000A, 1, 1, 16'h000B, 1, 1, 0, 1));
    tbl.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h0000, 0, 1, 0, 0));
    // 3-beat A packet locks out B
    tbl.push_back(mk(0, 1, 16'h0001, 0, 1, 16'h00B1, 1, 1, 1, 0));
    tbl.push_back(mk(0, 1, 16'h0002, 0, 1, 16'h00B1, 1, 1, 1, 0));
    tbl.push_back(mk(0, 1, 16'h0003, 1, 1, 16'h00B1, 1, 1, 1, 0));
    tbl.push_back(mk(0, 0, 16'h0000, 0, 1, 16'h00B1, 1, 1, 0, 1));
    tbl.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h0000, 0, 1, 0, 0));
    // output backpressure for 4 cycles, then drain and load together
    tbl.push_back(mk(0, 1, 16'h0C01, 1, 0, 16'h0000, 0, 1, 1, 0));
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk(0, 1, 16'h0C02, 1, 1, 16'h0C03, 1, 0, 0, 0));
    tbl.push_back(mk(0, 1, 16'h0C02, 1, 1, 16'h0C03, 1, 1, 0, 1));
    tbl.push_back(mk(0, 1, 16'h0C02, 1, 0, 16'h0000, 0, 1, 1, 0));
    tbl.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h0000, 0, 1, 0, 0));
    // locked source gap: A idles mid-packet, B stays shut out
    tbl.push_back(mk(0, 1, 16'h0D01, 0, 0, 16'h0000, 0, 1, 1, 0));
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(0, 0, 16'h0000, 0, 1, 16'h0D0B, 1, 1, 1, 0));
    tbl.push_back(mk(0, 1, 16'h0D02, 1, 1, 16'h0D0B, 1, 1, 1, 0));
    tbl.push_back(mk(0, 0, 16'h0000, 0, 1, 16'h0D0B, 1, 1, 0, 1));
    tbl.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h0000, 0, 1, 0, 0));
    // reset in LOCK_B with a held beat, then arbitration restarts with PRIO=A
    tbl.push_back(mk(0, 0, 16'h0000, 0, 1, 16'h0E01, 0, 1, 0, 1));
    tbl.push_back(mk(0, 1, 16'h0E0A, 1, 1, 16'h0E02, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 16'h0E0A, 1, 1, 16'h0E02, 0, 1, 0, 0));
    tbl.push_back(mk(0, 1, 16'h0E0A, 1, 1, 16'h0E03, 1, 1, 1, 0));
    tbl.push_back(mk(0, 0, 16'h0000, 0, 1, 16'h0E03, 1, 1, 0, 1));
    tbl.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h0000, 0, 1, 0, 0));

    RESET = 1'b1;
    repeat (2) @(posedge CLK);
    chk("init_out_valid", 0, 32'(OUT_VALID), 32'd0);
    chk("init_ready", 0, 32'({A_READY, B_READY}), 32'd0);

    for (int i = 0; i < tbl.size(); i++) step(tbl[i], i + 1);

    // random A-only traffic with random sink stalls
    for (int i = 0; i < 60; i++) begin
      exp_full = (exp_q.size() != 0);
      ordy     = 1'($urandom_range(0, 1));
      d        = WIDTH'($urandom_range(0, 16'hFFFF));
      last     = (i == 59) ? 1'b1 : 1'($urandom_range(0, 1));
      v = mk(0, 1, d, last, 0, 16'h0000, 0, ordy, !exp_full || ordy, 0);
      step(v, 1000 + i);
    end
    step(mk(0, 0, 16'h0000, 0, 0, 16'h0000, 0, 1, 0, 0), 2000);
    step(mk(0, 0, 16'h0000, 0, 0, 16'h0000, 0, 1, 0, 0), 2001);
    chk("queue_empty", 2002, 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
